// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The loader uses the slave modport; the byte source / memory side uses master.
interface program_loader_if #(
    parameter int AW = 6,
    parameter int DW = 13
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/program_loader.sv
// Assembles SYNC/LEN/{HI,LO}xN/CHK byte frames into DW-bit words and writes them
// to program memory, holding the CPU until a frame with a good checksum lands.
module program_loader #(
    parameter int         AW   = 6,
    parameter int         DW   = 13,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input  logic           clk,
    input  logic           rst_n,
    program_loader_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK} state_e;

    state_e          state_q, state_d;
    logic [AW:0]     addr_q, addr_d;
    logic [AW:0]     len_q, len_d;
    logic [7:0]      xor_q, xor_d;
    logic [DW-9:0]   hi_q, hi_d;
    logic            in_ready_q, in_ready_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            xfer;

    assign xfer = bus.in_valid & in_ready_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        xor_d       = xor_q;
        hi_d        = hi_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        err_d       = err_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: if (xfer && bus.in_data == SYNC) begin
                state_d    = S_LEN;
                cpu_hold_d = 1'b1;
                err_d      = 1'b0;
            end
            S_LEN: if (xfer) begin
                if (bus.in_data == 8'd0 || int'(bus.in_data) > DEPTH) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    len_d   = bus.in_data[AW:0];
                    xor_d   = bus.in_data;
                    addr_d  = '0;
                    state_d = S_HI;
                end
            end
            S_HI: if (xfer) begin
                hi_d    = bus.in_data[DW-9:0];
                xor_d   = xor_q ^ bus.in_data;
                state_d = S_LO;
            end
            S_LO: if (xfer) begin
                xor_d       = xor_q ^ bus.in_data;
                mem_wdata_d = {hi_q, bus.in_data};
                mem_addr_d  = addr_q[AW-1:0];
                state_d     = S_WR;
            end
            S_WR: begin
                addr_d  = addr_q + 1'b1;
                state_d = (addr_d == len_q) ? S_CHK : S_HI;
            end
            S_CHK: if (xfer) begin
                state_d = S_IDLE;
                if (bus.in_data == xor_q) begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready and the write strobe are registered from the next state so both line up with WR.
        in_ready_d = (state_d != S_WR);
        mem_we_d   = (state_d == S_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            xor_q       <= '0;
            hi_q        <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            xor_q       <= xor_d;
            hi_q        <= hi_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
